// File: rtl/intersection_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : intersection_controller                                       |
// | Purpose  : Four-way traffic light FSM with latched pedestrian walk phase, |
// |            police override and a 2-bank traffic-count memory.            |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module intersection_controller #(
   parameter int GREEN_BASE  = 8,
   parameter int YELLOW_TIME = 3,
   parameter int PED_TIME    = 10,
   parameter int ADDR_W      = 7,
   parameter int DATA_W      = 4
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              police_Interrupt,
   input  logic              pedestrian_Hori_Street_Interrupt,
   input  logic              pedestrian_Vert_Street_Interrupt,
   input  logic [DATA_W-1:0] traffic_Street_0,
   input  logic [DATA_W-1:0] traffic_Street_1,
   input  logic              read_Write,
   input  logic              memory_Enable,
   input  logic [ADDR_W-1:0] address,
   input  logic              street,
   output logic [DATA_W-1:0] traffic_Street,
   output logic [2:0]        led_North,
   output logic [2:0]        led_South,
   output logic [2:0]        led_West,
   output logic [2:0]        led_East,
   output logic [1:0]        led_Hori_North_East,
   output logic [1:0]        led_Hori_North_West,
   output logic [1:0]        led_Hori_South_East,
   output logic [1:0]        led_Hori_South_West,
   output logic [1:0]        led_Vert_North_East,
   output logic [1:0]        led_Vert_North_West,
   output logic [1:0]        led_Vert_South_East,
   output logic [1:0]        led_Vert_South_West
);

   localparam int          c_cnt_w       = 5;
   localparam logic [2:0]  c_red         = 3'b100;
   localparam logic [2:0]  c_yellow      = 3'b010;
   localparam logic [2:0]  c_green       = 3'b001;
   localparam logic [1:0]  c_walk        = 2'b10;
   localparam logic [1:0]  c_dont_walk   = 2'b01;
   localparam logic [c_cnt_w-1:0] c_yellow_load = c_cnt_w'(YELLOW_TIME - 1);
   localparam logic [c_cnt_w-1:0] c_ped_load    = c_cnt_w'(PED_TIME - 1);

   typedef enum logic [2:0] {
      S_H_GREEN  = 3'd0,
      S_H_YELLOW = 3'd1,
      S_V_GREEN  = 3'd2,
      S_V_YELLOW = 3'd3,
      S_PED      = 3'd4,
      S_POLICE   = 3'd5
   } state_t;

   state_t               r_state, w_next_state;
   logic [c_cnt_w-1:0]   r_count, w_next_count;
   logic                 r_ped_h, r_ped_v;      // sticky request latches
   logic                 r_walk_h, r_walk_v;    // groups being served in the current PED
   logic                 r_after_v, w_after_v;  // PED exits to V_GREEN when set
   logic                 w_enter_ped;
   logic [c_cnt_w-1:0]   w_green_h, w_green_v;
   logic [2:0]           r_led_ns, r_led_we, w_led_ns, w_led_we;
   logic [1:0]           r_walk_led_h, r_walk_led_v, w_walk_led_h, w_walk_led_v;
   logic [DATA_W-1:0]    r_mem0 [2**ADDR_W];
   logic [DATA_W-1:0]    r_mem1 [2**ADDR_W];
   logic [DATA_W-1:0]    r_rd_data;

   assign w_green_h = c_cnt_w'(GREEN_BASE - 1) + c_cnt_w'(traffic_Street_0);
   assign w_green_v = c_cnt_w'(GREEN_BASE - 1) + c_cnt_w'(traffic_Street_1);

   always_comb begin
      w_next_state = r_state;
      w_next_count = r_count - c_cnt_w'(1);
      w_enter_ped  = 1'b0;
      w_after_v    = r_after_v;
      if (police_Interrupt) begin
         w_next_state = S_POLICE;
         w_next_count = r_count;
      end else if (r_state == S_POLICE) begin
         w_next_state = S_H_GREEN;
         w_next_count = w_green_h;
      end else if (r_count == '0) begin
         case (r_state)
            S_H_GREEN: begin
               w_next_state = S_H_YELLOW;
               w_next_count = c_yellow_load;
            end
            S_H_YELLOW: begin
               if (r_ped_h || r_ped_v) begin
                  w_next_state = S_PED;
                  w_next_count = c_ped_load;
                  w_enter_ped  = 1'b1;
                  w_after_v    = 1'b1;
               end else begin
                  w_next_state = S_V_GREEN;
                  w_next_count = w_green_v;
               end
            end
            S_V_GREEN: begin
               w_next_state = S_V_YELLOW;
               w_next_count = c_yellow_load;
            end
            S_V_YELLOW: begin
               if (r_ped_h || r_ped_v) begin
                  w_next_state = S_PED;
                  w_next_count = c_ped_load;
                  w_enter_ped  = 1'b1;
                  w_after_v    = 1'b0;
               end else begin
                  w_next_state = S_H_GREEN;
                  w_next_count = w_green_h;
               end
            end
            S_PED: begin
               w_next_state = r_after_v ? S_V_GREEN : S_H_GREEN;
               w_next_count = r_after_v ? w_green_v : w_green_h;
            end
            default: begin
               w_next_state = S_H_GREEN;
               w_next_count = w_green_h;
            end
         endcase
      end
   end

   // Lights are decoded from the next state so the output registers track r_state.
   always_comb begin
      w_led_ns     = c_red;
      w_led_we     = c_red;
      w_walk_led_h = c_dont_walk;
      w_walk_led_v = c_dont_walk;
      case (w_next_state)
         S_H_GREEN:  w_led_we = c_green;
         S_H_YELLOW: w_led_we = c_yellow;
         S_V_GREEN:  w_led_ns = c_green;
         S_V_YELLOW: w_led_ns = c_yellow;
         S_PED: begin
            if (w_enter_ped ? r_ped_h : r_walk_h) w_walk_led_h = c_walk;
            if (w_enter_ped ? r_ped_v : r_walk_v) w_walk_led_v = c_walk;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state      <= S_H_GREEN;
         r_count      <= w_green_h;
         r_ped_h      <= 1'b0;
         r_ped_v      <= 1'b0;
         r_walk_h     <= 1'b0;
         r_walk_v     <= 1'b0;
         r_after_v    <= 1'b0;
         r_led_ns     <= c_red;
         r_led_we     <= c_green;
         r_walk_led_h <= c_dont_walk;
         r_walk_led_v <= c_dont_walk;
      end else begin
         r_state      <= w_next_state;
         r_count      <= w_next_count;
         r_after_v    <= w_after_v;
         r_led_ns     <= w_led_ns;
         r_led_we     <= w_led_we;
         r_walk_led_h <= w_walk_led_h;
         r_walk_led_v <= w_walk_led_v;
         // Latches are handed to the walk phase on entry; same-cycle requests wait for the next one.
         r_ped_h      <= (w_enter_ped ? 1'b0 : r_ped_h) | pedestrian_Hori_Street_Interrupt;
         r_ped_v      <= (w_enter_ped ? 1'b0 : r_ped_v) | pedestrian_Vert_Street_Interrupt;
         if (w_enter_ped) begin
            r_walk_h <= r_ped_h;
            r_walk_v <= r_ped_v;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (memory_Enable && read_Write) begin
         r_mem0[address] <= traffic_Street_0;
         r_mem1[address] <= traffic_Street_1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rd_data <= '0;
      end else if (memory_Enable && !read_Write) begin
         r_rd_data <= street ? r_mem1[address] : r_mem0[address];
      end
   end

   assign traffic_Street      = r_rd_data;
   assign led_North           = r_led_ns;
   assign led_South           = r_led_ns;
   assign led_West            = r_led_we;
   assign led_East            = r_led_we;
   assign led_Hori_North_East = r_walk_led_h;
   assign led_Hori_North_West = r_walk_led_h;
   assign led_Hori_South_East = r_walk_led_h;
   assign led_Hori_South_West = r_walk_led_h;
   assign led_Vert_North_East = r_walk_led_v;
   assign led_Vert_North_West = r_walk_led_v;
   assign led_Vert_South_East = r_walk_led_v;
   assign led_Vert_South_West = r_walk_led_v;

endmodule
`default_nettype wire

// File: tb/tb_intersection_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_intersection_controller                                    |
// | Purpose  : Scoreboard bench for intersection_controller with a phase-    |
// |            and-time-left reference model.                                |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_intersection_controller;

   localparam int GB = 8;
   localparam int YT = 3;
   localparam int PT = 10;

   localparam int P_WE_GREEN  = 0;
   localparam int P_WE_YELLOW = 1;
   localparam int P_NS_GREEN  = 2;
   localparam int P_NS_YELLOW = 3;
   localparam int P_WALK      = 4;
   localparam int P_POLICE    = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       police = 1'b0;
   logic       req_h = 1'b0, req_v = 1'b0;
   logic [3:0] t0 = 4'd0, t1 = 4'd4;
   logic       rw = 1'b0, mem_en = 1'b0, street = 1'b0;
   logic [6:0] address = 7'd0;

   logic [3:0] traffic_Street;
   logic [2:0] led_North, led_South, led_West, led_East;
   logic [1:0] h_ne, h_nw, h_se, h_sw, v_ne, v_nw, v_se, v_sw;

   always #5 clock = ~clock;

   intersection_controller dut (
      .clock(clock), .reset(reset), .police_Interrupt(police),
      .pedestrian_Hori_Street_Interrupt(req_h), .pedestrian_Vert_Street_Interrupt(req_v),
      .traffic_Street_0(t0), .traffic_Street_1(t1), .read_Write(rw),
      .memory_Enable(mem_en), .address(address), .street(street),
      .traffic_Street(traffic_Street),
      .led_North(led_North), .led_South(led_South), .led_West(led_West), .led_East(led_East),
      .led_Hori_North_East(h_ne), .led_Hori_North_West(h_nw),
      .led_Hori_South_East(h_se), .led_Hori_South_West(h_sw),
      .led_Vert_North_East(v_ne), .led_Vert_North_West(v_nw),
      .led_Vert_South_East(v_se), .led_Vert_South_West(v_sw)
   );

   typedef struct packed {
      logic [11:0] veh;
      logic [15:0] ped;
      logic [3:0]  mem;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   // Reference model: current phase plus cycles still to be spent in it.
   int         m_phase = P_WE_GREEN;
   int         m_left  = 1;
   int         m_after = P_NS_GREEN;
   bit         m_lh, m_lv, m_wh, m_wv;
   logic [3:0] m_mem0 [128];
   logic [3:0] m_mem1 [128];
   logic [3:0] m_out;

   function automatic logic [11:0] veh_of(int p);
      case (p)
         P_WE_GREEN:  return {3'b100, 3'b100, 3'b001, 3'b001};
         P_WE_YELLOW: return {3'b100, 3'b100, 3'b010, 3'b010};
         P_NS_GREEN:  return {3'b001, 3'b001, 3'b100, 3'b100};
         P_NS_YELLOW: return {3'b010, 3'b010, 3'b100, 3'b100};
         default:     return {4{3'b100}};
      endcase
   endfunction

   function automatic int green_len(int p);
      return GB + ((p == P_NS_GREEN) ? int'(t1) : int'(t0));
   endfunction

   task automatic model_step();
      bit         go_walk;
      logic [1:0] hl, vl;
      exp_t       e;
      go_walk = 1'b0;
      if (reset) begin
         m_phase = P_WE_GREEN;
         m_left  = green_len(P_WE_GREEN);
         m_lh = 1'b0; m_lv = 1'b0; m_wh = 1'b0; m_wv = 1'b0;
      end else begin
         if (police) begin
            m_phase = P_POLICE;
         end else if (m_phase == P_POLICE) begin
            m_phase = P_WE_GREEN;
            m_left  = green_len(P_WE_GREEN);
         end else if (m_left > 1) begin
            m_left--;
         end else begin
            case (m_phase)
               P_WE_GREEN: begin m_phase = P_WE_YELLOW; m_left = YT; end
               P_NS_GREEN: begin m_phase = P_NS_YELLOW; m_left = YT; end
               P_WE_YELLOW, P_NS_YELLOW: begin
                  m_after = (m_phase == P_WE_YELLOW) ? P_NS_GREEN : P_WE_GREEN;
                  if (m_lh || m_lv) begin
                     go_walk = 1'b1;
                     m_phase = P_WALK;
                     m_left  = PT;
                  end else begin
                     m_phase = m_after;
                     m_left  = green_len(m_after);
                  end
               end
               default: begin
                  m_phase = m_after;
                  m_left  = green_len(m_after);
               end
            endcase
         end
         if (go_walk) begin
            m_wh = m_lh; m_wv = m_lv;
            m_lh = req_h; m_lv = req_v;
         end else begin
            m_lh = m_lh | req_h; m_lv = m_lv | req_v;
         end
      end
      if (reset) m_out = 4'd0;
      else if (mem_en && !rw) m_out = street ? m_mem1[address] : m_mem0[address];
      if (mem_en && rw) begin
         m_mem0[address] = t0;
         m_mem1[address] = t1;
      end
      hl = (m_phase == P_WALK && m_wh) ? 2'b10 : 2'b01;
      vl = (m_phase == P_WALK && m_wv) ? 2'b10 : 2'b01;
      e.veh = veh_of(m_phase);
      e.ped = {hl, hl, hl, hl, vl, vl, vl, vl};
      e.mem = m_out;
      q.push_back(e);
   endtask

   initial forever begin
      @(posedge clock);
      model_step();
   end

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
   endtask

   initial forever begin
      exp_t e;
      @(negedge clock);
      if (q.size() > 0) begin
         e = q.pop_front();
         check("vehicle_lights", 32'({led_North, led_South, led_West, led_East}), 32'(e.veh));
         check("ped_lights", 32'({h_ne, h_nw, h_se, h_sw, v_ne, v_nw, v_se, v_sw}), 32'(e.ped));
         check("mem_read", 32'(traffic_Street), 32'(e.mem));
      end
   end

   task automatic cyc(int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic timeout_fail(string name);
      n_checks++;
      $display("FAIL %s: wait expired, actual=timeout required=event", name);
   endtask

   initial begin
      int k;
      cyc(2);
      reset = 1'b0;
      // Fill both banks so any later random read has defined contents.
      mem_en = 1'b1; rw = 1'b1;
      for (int a = 0; a < 128; a++) begin
         address = 7'(a);
         t0 = 4'($urandom_range(0, 15));
         t1 = 4'($urandom_range(0, 15));
         cyc(1);
      end
      mem_en = 1'b0; rw = 1'b0;

      // Baseline cycle with fixed traffic counts.
      t0 = 4'd0; t1 = 4'd4; reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      cyc(30);

      // Single horizontal request during W/E green.
      reset = 1'b1; cyc(1); reset = 1'b0; cyc(2);
      req_h = 1'b1; cyc(1); req_h = 1'b0;
      cyc(40);

      // Both requests in the same cycle.
      req_h = 1'b1; req_v = 1'b1; cyc(1); req_h = 1'b0; req_v = 1'b0;
      cyc(50);

      // Police override during N/S green.
      k = 0;
      while (led_North !== 3'b001 && k < 100) begin cyc(1); k++; end
      if (k >= 100) timeout_fail("wait_ns_green");
      cyc(3);
      police = 1'b1; cyc(5); police = 1'b0;
      cyc(20);

      // Memory write then reads from both banks, then hold.
      mem_en = 1'b1; rw = 1'b1; address = 7'd7; t0 = 4'd5; t1 = 4'd9; cyc(1);
      rw = 1'b0; street = 1'b0; cyc(1);
      street = 1'b1; cyc(1);
      mem_en = 1'b0; street = 1'b0; t0 = 4'd0; t1 = 4'd4; cyc(4);

      // Reset in the middle of a walk phase.
      req_v = 1'b1; cyc(1); req_v = 1'b0;
      k = 0;
      while (v_ne !== 2'b10 && k < 200) begin cyc(1); k++; end
      if (k >= 200) timeout_fail("wait_walk");
      cyc(3);
      reset = 1'b1; cyc(1); reset = 1'b0;
      mem_en = 1'b1; address = 7'd7; street = 1'b1; cyc(1); mem_en = 1'b0;
      cyc(5);

      // Randomised traffic, requests, police episodes, memory traffic and rare resets.
      for (int i = 0; i < 3000; i++) begin
         t0     = 4'($urandom_range(0, 15));
         t1     = 4'($urandom_range(0, 15));
         req_h  = ($urandom_range(0, 19) == 0);
         req_v  = ($urandom_range(0, 19) == 0);
         if (police) police = ($urandom_range(0, 5) != 0);
         else        police = ($urandom_range(0, 149) == 0);
         reset  = ($urandom_range(0, 499) == 0);
         mem_en = ($urandom_range(0, 2) == 0);
         rw     = ($urandom_range(0, 3) == 0);
         street = 1'($urandom_range(0, 1));
         address = 7'($urandom_range(0, 127));
         cyc(1);
      end
      reset = 1'b0; police = 1'b0; req_h = 1'b0; req_v = 1'b0; mem_en = 1'b0;
      cyc(3);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
